// File: rtl/lsq_multi_cdb_pkg.sv
// Shared constants for the load/store queue: opcodes, access widths, FSM states.
// Helper: op_width maps an opcode to its access size in bytes.
package lsq_multi_cdb_pkg;

  localparam int unsigned OP_LB  = 10;
  localparam int unsigned OP_LH  = 11;
  localparam int unsigned OP_LW  = 12;
  localparam int unsigned OP_LBU = 13;
  localparam int unsigned OP_LHU = 14;
  localparam int unsigned OP_SB  = 15;
  localparam int unsigned OP_SH  = 16;
  localparam int unsigned OP_SW  = 17;

  localparam int unsigned ROB_WIDTH_BIT = 4;
  localparam int unsigned REG_ID_BIT    = 5;

  localparam logic [2:0] WIDTH_BYTE = 3'd1;
  localparam logic [2:0] WIDTH_HALF = 3'd2;
  localparam logic [2:0] WIDTH_WORD = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } lsq_state_e;

  // Access size in bytes for a memory opcode.
  function automatic logic [2:0] op_width(input logic [31:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return WIDTH_BYTE;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return WIDTH_HALF;
    return WIDTH_WORD;
  endfunction

endpackage

// File: rtl/lsq_multi_cdb_load_ext.sv
// Load data extension: raw memory word -> architectural value per load opcode.
// Ports: op_in (load opcode), raw_in (raw data), value_c (extended value, combinational).
module lsq_load_ext
  import lsq_multi_cdb_pkg::*;
#(
  parameter int unsigned OP_BITS = 6
) (
  input  logic [OP_BITS-1:0] op_in,
  input  logic [31:0]        raw_in,
  output logic [31:0]        value_c
);

  always_comb begin
    value_c = raw_in;
    if (op_in == OP_BITS'(OP_LB))       value_c = {{24{raw_in[7]}}, raw_in[7:0]};
    else if (op_in == OP_BITS'(OP_LBU)) value_c = {24'b0, raw_in[7:0]};
    else if (op_in == OP_BITS'(OP_LH))  value_c = {{16{raw_in[15]}}, raw_in[15:0]};
    else if (op_in == OP_BITS'(OP_LHU)) value_c = {16'b0, raw_in[15:0]};
  end

endmodule

// File: rtl/lsq_multi_cdb.sv
// In-order load/store queue with multi-CDB operand wakeup.
// Ports: clk_in/rst_in/rdy_in control; task_in + operand fields enqueue; mem_* is the
// single-outstanding memory interface; cdb_* snooped result buses; ld_*/st_* completion
// pulses; lsb_full/lsb_count occupancy; rob_head gates store issue; clear_all flushes.
module lsq_multi_cdb
  import lsq_multi_cdb_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NUM_CDB  = 2,
  parameter int unsigned ROB_BITS = 4,
  parameter int unsigned OP_BITS  = 6
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  output logic                        lsb_full,
  output logic [$clog2(DEPTH):0]      lsb_count,
  input  logic                        task_in,
  input  logic [OP_BITS-1:0]          op_type,
  input  logic [31:0]                 vj_in,
  input  logic [31:0]                 vk_in,
  input  logic [ROB_BITS-1:0]         qj_in,
  input  logic [ROB_BITS-1:0]         qk_in,
  input  logic                        j_in,
  input  logic                        k_in,
  input  logic [31:0]                 imm_in,
  input  logic [ROB_BITS-1:0]         dest_in,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [2:0]                  mem_width,
  output logic [31:0]                 mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic                        mem_ack,
  input  logic                        mem_resp_valid,
  input  logic [31:0]                 mem_rdata,
  input  logic [ROB_BITS-1:0]         rob_head,
  input  logic                        clear_all,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*ROB_BITS-1:0] cdb_tag,
  input  logic [NUM_CDB*32-1:0]       cdb_value,
  output logic                        ld_valid,
  output logic [ROB_BITS-1:0]         ld_tag,
  output logic [31:0]                 ld_value,
  output logic                        st_done,
  output logic [ROB_BITS-1:0]         st_tag
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Entry storage
  logic [DEPTH-1:0]    valid_q, valid_d, j_q, j_d, k_q, k_d;
  logic [OP_BITS-1:0]  op_q  [DEPTH];
  logic [OP_BITS-1:0]  op_d  [DEPTH];
  logic [31:0]         vj_q  [DEPTH];
  logic [31:0]         vj_d  [DEPTH];
  logic [31:0]         vk_q  [DEPTH];
  logic [31:0]         vk_d  [DEPTH];
  logic [31:0]         imm_q [DEPTH];
  logic [31:0]         imm_d [DEPTH];
  logic [ROB_BITS-1:0] qj_q  [DEPTH];
  logic [ROB_BITS-1:0] qj_d  [DEPTH];
  logic [ROB_BITS-1:0] qk_q  [DEPTH];
  logic [ROB_BITS-1:0] qk_d  [DEPTH];
  logic [ROB_BITS-1:0] tag_q [DEPTH];
  logic [ROB_BITS-1:0] tag_d [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;

  lsq_state_e state_q, state_d;

  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [2:0]          mem_width_q, mem_width_d;
  logic [31:0]         mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic                ld_valid_q, ld_valid_d, st_done_q, st_done_d;
  logic [ROB_BITS-1:0] ld_tag_q, ld_tag_d, st_tag_q, st_tag_d, lat_tag_q, lat_tag_d;
  logic [31:0]         ld_value_q, ld_value_d;
  logic [OP_BITS-1:0]  lat_op_q, lat_op_d;

  logic        enq_c, deq_c, head_store_c, head_ready_c, issue_c;
  logic        enq_j_c, enq_k_c;
  logic [31:0] enq_vj_c, enq_vk_c, ext_value_c, head_wdata_c;
  logic [2:0]  head_width_c;

  lsq_load_ext #(.OP_BITS(OP_BITS)) u_ext (
    .op_in   (lat_op_q),
    .raw_in  (mem_rdata),
    .value_c (ext_value_c)
  );

  // Head entry issue conditions
  always_comb begin
    head_store_c = (op_q[head_q] >= OP_BITS'(OP_SB)) && (op_q[head_q] <= OP_BITS'(OP_SW));
    head_ready_c = valid_q[head_q] && j_q[head_q] && k_q[head_q];
    issue_c      = head_ready_c && (!head_store_c || (rob_head == tag_q[head_q]));
    head_width_c = op_width(32'(op_q[head_q]));
    case (head_width_c)
      WIDTH_BYTE: head_wdata_c = {24'b0, vk_q[head_q][7:0]};
      WIDTH_HALF: head_wdata_c = {16'b0, vk_q[head_q][15:0]};
      default:    head_wdata_c = vk_q[head_q];
    endcase
  end

  // Operand wakeup for the entry being enqueued
  always_comb begin
    enq_j_c  = j_in;
    enq_k_c  = k_in;
    enq_vj_c = vj_in;
    enq_vk_c = vk_in;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (cdb_valid[c] && !j_in && qj_in == cdb_tag[c*ROB_BITS +: ROB_BITS]) begin
        enq_j_c  = 1'b1;
        enq_vj_c = cdb_value[c*32 +: 32];
      end
      if (cdb_valid[c] && !k_in && qk_in == cdb_tag[c*ROB_BITS +: ROB_BITS]) begin
        enq_k_c  = 1'b1;
        enq_vk_c = cdb_value[c*32 +: 32];
      end
    end
    if (ld_valid_q && !j_in && qj_in == ld_tag_q) begin
      enq_j_c  = 1'b1;
      enq_vj_c = ld_value_q;
    end
    if (ld_valid_q && !k_in && qk_in == ld_tag_q) begin
      enq_k_c  = 1'b1;
      enq_vk_c = ld_value_q;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (issue_c) state_d = ST_REQ;
      ST_REQ:   if (mem_ack) state_d = mem_we_q ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (mem_resp_valid) state_d = ST_IDLE;
      ST_DRAIN: if (mem_resp_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // A load already handed to memory must have its response swallowed.
    if (clear_all) begin
      if (((state_q == ST_WAIT || state_q == ST_DRAIN) && !mem_resp_valid) ||
          (state_q == ST_REQ && mem_ack && !mem_we_q)) state_d = ST_DRAIN;
      else state_d = ST_IDLE;
    end
  end

  // FSM outputs
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_width_d = mem_width_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lat_op_d    = lat_op_q;
    lat_tag_d   = lat_tag_q;
    ld_valid_d  = 1'b0;
    ld_tag_d    = ld_tag_q;
    ld_value_d  = ld_value_q;
    st_done_d   = 1'b0;
    st_tag_d    = st_tag_q;
    deq_c       = 1'b0;
    case (state_q)
      ST_IDLE: if (issue_c) begin
        mem_req_d   = 1'b1;
        mem_we_d    = head_store_c;
        mem_width_d = head_width_c;
        mem_addr_d  = vj_q[head_q] + imm_q[head_q];
        mem_wdata_d = head_wdata_c;
        lat_op_d    = op_q[head_q];
        lat_tag_d   = tag_q[head_q];
      end
      ST_REQ: if (mem_ack) begin
        mem_req_d = 1'b0;
        deq_c     = 1'b1;
        if (mem_we_q) begin
          st_done_d = 1'b1;
          st_tag_d  = lat_tag_q;
        end
      end
      ST_WAIT: if (mem_resp_valid) begin
        ld_valid_d = 1'b1;
        ld_tag_d   = lat_tag_q;
        ld_value_d = ext_value_c;
      end
      default: ;
    endcase
    if (clear_all) begin
      mem_req_d  = 1'b0;
      ld_valid_d = 1'b0;
      st_done_d  = 1'b0;
    end
  end

  // Queue contents, pointers and occupancy
  always_comb begin
    enq_c   = task_in && !clear_all;
    valid_d = valid_q;
    j_d     = j_q;
    k_d     = k_q;
    op_d    = op_q;
    vj_d    = vj_q;
    vk_d    = vk_q;
    imm_d   = imm_q;
    qj_d    = qj_q;
    qk_d    = qk_q;
    tag_d   = tag_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int c = 0; c < NUM_CDB; c++) begin
        if (valid_q[i] && cdb_valid[c] && !j_q[i] && qj_q[i] == cdb_tag[c*ROB_BITS +: ROB_BITS]) begin
          j_d[i]  = 1'b1;
          vj_d[i] = cdb_value[c*32 +: 32];
        end
        if (valid_q[i] && cdb_valid[c] && !k_q[i] && qk_q[i] == cdb_tag[c*ROB_BITS +: ROB_BITS]) begin
          k_d[i]  = 1'b1;
          vk_d[i] = cdb_value[c*32 +: 32];
        end
      end
      if (valid_q[i] && ld_valid_q && !j_q[i] && qj_q[i] == ld_tag_q) begin
        j_d[i]  = 1'b1;
        vj_d[i] = ld_value_q;
      end
      if (valid_q[i] && ld_valid_q && !k_q[i] && qk_q[i] == ld_tag_q) begin
        k_d[i]  = 1'b1;
        vk_d[i] = ld_value_q;
      end
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (deq_c) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
      count_d         = count_d - CNT_W'(1);
    end
    // Written after the dequeue so a full-queue swap re-fills the freed slot.
    if (enq_c) begin
      valid_d[tail_q] = 1'b1;
      op_d[tail_q]    = op_type;
      vj_d[tail_q]    = enq_vj_c;
      vk_d[tail_q]    = enq_vk_c;
      j_d[tail_q]     = enq_j_c;
      k_d[tail_q]     = enq_k_c;
      qj_d[tail_q]    = qj_in;
      qk_d[tail_q]    = qk_in;
      imm_d[tail_q]   = imm_in;
      tag_d[tail_q]   = dest_in;
      tail_d          = tail_q + PTR_W'(1);
      count_d         = count_d + CNT_W'(1);
    end
    if (clear_all) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    full_d = (count_d == CNT_W'(DEPTH));
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in)      state_q <= ST_IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q     <= '0;
      j_q         <= '0;
      k_q         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
        imm_q[i] <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        tag_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_width_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lat_op_q    <= '0;
      lat_tag_q   <= '0;
      ld_valid_q  <= 1'b0;
      ld_tag_q    <= '0;
      ld_value_q  <= '0;
      st_done_q   <= 1'b0;
      st_tag_q    <= '0;
    end else if (rdy_in) begin
      valid_q     <= valid_d;
      j_q         <= j_d;
      k_q         <= k_d;
      op_q        <= op_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      imm_q       <= imm_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      tag_q       <= tag_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      full_q      <= full_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_width_q <= mem_width_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lat_op_q    <= lat_op_d;
      lat_tag_q   <= lat_tag_d;
      ld_valid_q  <= ld_valid_d;
      ld_tag_q    <= ld_tag_d;
      ld_value_q  <= ld_value_d;
      st_done_q   <= st_done_d;
      st_tag_q    <= st_tag_d;
    end
  end

  assign lsb_full  = full_q;
  assign lsb_count = count_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_width = mem_width_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ld_valid  = ld_valid_q;
  assign ld_tag    = ld_tag_q;
  assign ld_value  = ld_value_q;
  assign st_done   = st_done_q;
  assign st_tag    = st_tag_q;

endmodule
